// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational 32-bit ALU between NUM_REQ
// requesters; one operation in flight, result returned on a valid/ready channel.

module alu_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] result,
    output logic        zero,
    output logic        carry_out,
    output logic        overflow
);
    logic [32:0] sum;

    // SUB carry_out is the no-borrow flag of a + ~b + 1 (set when a >= b unsigned)
    always_comb begin
        sum       = '0;
        result    = '0;
        carry_out = 1'b0;
        overflow  = 1'b0;
        case (op)
            3'b000: begin
                sum       = {1'b0, a} + {1'b0, b};
                result    = sum[31:0];
                carry_out = sum[32];
                overflow  = (a[31] == b[31]) && (result[31] != a[31]);
            end
            3'b001: begin
                sum       = {1'b0, a} + {1'b0, ~b} + 33'd1;
                result    = sum[31:0];
                carry_out = sum[32];
                overflow  = (a[31] != b[31]) && (result[31] != a[31]);
            end
            3'b010:  result = a & b;
            3'b011:  result = a | b;
            3'b100:  result = a ^ b;
            3'b101:  result = ~(a & b);
            3'b110:  result = ~a;
            default: result = a;
        endcase
        zero = (result == '0);
    end
endmodule

module alu_rr_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*3-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_carry,
    output logic                 rsp_ovf,
    output logic                 busy
);
    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]        op_a, op_b;
    logic [2:0]         op_code;
    logic [ID_W-1:0]    op_id, last_grant, gnt;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               gnt_found, req_hs;
    logic [IW:0]        idx;
    logic [31:0]        sel_a, sel_b, alu_result;
    logic [2:0]         sel_op;
    logic               alu_zero, alu_carry, alu_ovf;

    // Search starts just after the last grant and wraps modulo NUM_REQ
    always_comb begin
        gnt_found = 1'b0;
        gnt       = '0;
        gnt_oh    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (IW+1)'(last_grant) + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_REQ)) idx = idx - (IW+1)'(NUM_REQ);
            if (!gnt_found && req_valid[idx[IW-1:0]]) begin
                gnt_found           = 1'b1;
                gnt                 = ID_W'(idx);
                gnt_oh[idx[IW-1:0]] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_a  = 32'(req_a >> (int'(gnt) * 32));
        sel_b  = 32'(req_b >> (int'(gnt) * 32));
        sel_op = 3'(req_op >> (int'(gnt) * 3));
    end

    assign req_hs = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && gnt_found) req_ready = gnt_oh;
        busy = (state != IDLE);
    end

    // Operand registers only load on a grant, so the ALU inputs stay quiet in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= '0;
            op_id      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_hs) begin
                    op_a       <= sel_a;
                    op_b       <= sel_b;
                    op_code    <= sel_op;
                    op_id      <= gnt;
                    last_grant <= gnt;
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_carry  <= alu_carry;
                    rsp_ovf    <= alu_ovf;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                end
                RESP: if (rsp_ready) rsp_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    alu_32bit u_alu (
        .a         (op_a),
        .b         (op_b),
        .op        (op_code),
        .result    (alu_result),
        .zero      (alu_zero),
        .carry_out (alu_carry),
        .overflow  (alu_ovf)
    );
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed and randomized bench for alu_rr_scheduler with three requesters and
// an arithmetic ALU / round-robin reference model.

module tb_alu_rr_scheduler;
    localparam int N   = 3;
    localparam int IDW = 2;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*32-1:0]   req_a, req_b;
    logic [N*3-1:0]    req_op;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [31:0]       rsp_result;
    logic              rsp_zero, rsp_carry, rsp_ovf, busy;

    int errors = 0;
    int checks = 0;
    int lastg;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_ovf(rsp_ovf), .busy(busy)
    );

    // Returns {zero, carry, ovf, result}
    function automatic logic [34:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, sr;
        logic [31:0] r;
        logic c, v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            3'd0: begin r = a + b; c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF; sr = sa + sb; v = (sr > MAXV) || (sr < MINV); end
            3'd1: begin r = a - b; c = (a >= b); sr = sa - sb; v = (sr > MAXV) || (sr < MINV); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~(a & b);
            3'd6: r = ~a;
            default: r = a;
        endcase
        return {(r == 32'd0), c, v, r};
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int j = 1; j <= N; j++)
            if (v[(last + j) % N]) return (last + j) % N;
        return -1;
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[3*i +: 3]  = op;
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
        lastg = N - 1;
    endtask

    task automatic wait_ready(input string tag, input int i);
        int n = 0;
        #1;
        while (!req_ready[i] && n < 20) begin step(1); n++; end
        chk({tag, ".ready"}, 32'(req_ready), 32'(1) << i);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        do begin step(1); n++; end while (!rsp_valid && n < 20);
    endtask

    task automatic check_rsp(input string tag, input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [34:0] e;
        e = ref_alu(op, a, b);
        chk({tag, ".valid"},  32'(rsp_valid), 32'd1);
        chk({tag, ".id"},     32'(rsp_id), 32'(id));
        chk({tag, ".result"}, rsp_result, e[31:0]);
        chk({tag, ".zero"},   32'(rsp_zero), 32'(e[34]));
        chk({tag, ".carry"},  32'(rsp_carry), 32'(e[33]));
        chk({tag, ".ovf"},    32'(rsp_ovf), 32'(e[32]));
    endtask

    task automatic run_one(input string tag, input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        set_req(i, op, a, b);
        req_valid = N'(1) << i;
        wait_ready(tag, i);
        step(1);
        req_valid = '0;
        lastg = i;
        wait_rsp(n);
        check_rsp(tag, i, op, a, b);
        step(1);
        chk({tag, ".done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, g, stall, seen;
        logic [2:0] eop;
        logic [31:0] ea, eb, hold;

        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
        step(2);
        req_valid = '1; #1;
        chk("reset.req_ready", 32'(req_ready), 32'd0);
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.rsp_id", 32'(rsp_id), 32'd0);
        chk("reset.rsp_result", rsp_result, 32'd0);
        chk("reset.flags", {29'd0, rsp_zero, rsp_carry, rsp_ovf}, 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        req_valid = '0;
        step(1);
        rst_n = 1'b1;
        step(1);

        // single ADD with latency
        set_req(0, 3'd0, 32'd5, 32'd3);
        req_valid = 3'b001; #1;
        chk("add.req_ready", 32'(req_ready), 32'd1);
        step(1);
        req_valid = '0;
        chk("add.exec_valid", 32'(rsp_valid), 32'd0);
        chk("add.exec_busy", 32'(busy), 32'd1);
        step(1);
        chk("add.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add.rsp_id", 32'(rsp_id), 32'd0);
        chk("add.result", rsp_result, 32'd8);
        chk("add.zero", 32'(rsp_zero), 32'd0);
        chk("add.ovf", 32'(rsp_ovf), 32'd0);
        rsp_ready = 1'b1;
        step(1);
        chk("add.after_hs_valid", 32'(rsp_valid), 32'd0);
        chk("add.after_hs_busy", 32'(busy), 32'd0);
        chk("add.after_hs_hold", rsp_result, 32'd8);

        // simultaneous requests alternate 0,1,0,1,... at 3-cycle interval
        do_reset();
        rsp_ready = 1'b1;
        set_req(0, 3'd1, 32'd5, 32'd7);
        set_req(1, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
        req_valid = 3'b011;
        for (int k = 0; k < 6; k++) begin
            g = rr_pick(req_valid, lastg);
            lastg = g;
            wait_rsp(n);
            chk($sformatf("sim%0d.interval", k), 32'(n), (k == 0) ? 32'd2 : 32'd3);
            if (g == 0) check_rsp($sformatf("sim%0d", k), 0, 3'd1, 32'd5, 32'd7);
            else        check_rsp($sformatf("sim%0d", k), 1, 3'd2, 32'hF0F0F0F0, 32'h0FF00FF0);
            if (k == 0) chk("sim.first_result", rsp_result, 32'hFFFFFFFE);
            if (k == 1) chk("sim.second_result", rsp_result, 32'h00F000F0);
            if (k == 5) req_valid = '0;
        end
        step(1);

        // backpressure
        rsp_ready = 1'b0;
        set_req(1, 3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        req_valid = 3'b010;
        lastg = 1;
        wait_rsp(n);
        check_rsp("bp", 1, 3'd4, 32'h1234_5678, 32'h0F0F_0F0F);
        hold = rsp_result;
        set_req(0, 3'd3, 32'hA000_0000, 32'h0000_000A);
        req_valid = 3'b011;
        for (int c = 0; c < 5; c++) begin
            step(1);
            chk($sformatf("bp%0d.valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp%0d.result", c), rsp_result, hold);
            chk($sformatf("bp%0d.id", c), 32'(rsp_id), 32'd1);
            chk($sformatf("bp%0d.req_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        step(1);
        chk("bp.release_valid", 32'(rsp_valid), 32'd0);
        chk("bp.release_ready", 32'(req_ready), 32'd1);
        step(1);
        req_valid = '0;
        lastg = 0;
        chk("bp.accepted_busy", 32'(busy), 32'd1);
        wait_rsp(n);
        check_rsp("bp.next", 0, 3'd3, 32'hA000_0000, 32'h0000_000A);
        step(1);

        // flags and unary ops
        run_one("ovf", 0, 3'd0, 32'h7FFFFFFF, 32'h1);
        chk("ovf.result", rsp_result, 32'h80000000);
        chk("ovf.flag", 32'(rsp_ovf), 32'd1);
        chk("ovf.zero", 32'(rsp_zero), 32'd0);
        run_one("zero", 1, 3'd1, 32'h0000ABCD, 32'h0000ABCD);
        chk("zero.result", rsp_result, 32'd0);
        chk("zero.flag", 32'(rsp_zero), 32'd1);
        run_one("not_b0", 0, 3'd6, 32'h0000F0F0, 32'h0);
        chk("not_b0.result", rsp_result, 32'hFFFF0F0F);
        run_one("not_b1", 1, 3'd6, 32'h0000F0F0, 32'hFFFFFFFF);
        chk("not_b1.result", rsp_result, 32'hFFFF0F0F);
        run_one("pass_b0", 2, 3'd7, 32'h12345678, 32'h0);
        chk("pass_b0.result", rsp_result, 32'h12345678);
        run_one("pass_b1", 0, 3'd7, 32'h12345678, 32'hFFFFFFFF);
        chk("pass_b1.result", rsp_result, 32'h12345678);

        // reset mid-EXEC
        set_req(1, 3'd0, 32'd1, 32'd2);
        req_valid = 3'b010;
        wait_ready("rst", 1);
        step(1);
        req_valid = 3'b011;
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        step(2);
        req_valid = '0;
        rst_n = 1'b1;
        lastg = N - 1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (rsp_valid) seen++;
        end
        chk("rst.no_response", 32'(seen), 32'd0);
        set_req(0, 3'd2, 32'hFF00FF00, 32'h0F0F0F0F);
        req_valid = 3'b011; #1;
        chk("rst.first_grant", 32'(req_ready), 32'd1);
        step(1);
        req_valid = '0;
        lastg = 0;
        wait_rsp(n);
        check_rsp("rst.first", 0, 3'd2, 32'hFF00FF00, 32'h0F0F0F0F);
        step(1);

        // randomized traffic against the round-robin / arithmetic model
        do_reset();
        rsp_ready = 1'b1;
        for (int t = 0; t < 200; t++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 3'($urandom_range(0, 7)), rnd32(), rnd32());
                    req_valid[i] = 1'b1;
                end
            if (req_valid == '0) begin
                g = $urandom_range(0, N - 1);
                set_req(g, 3'($urandom_range(0, 7)), rnd32(), rnd32());
                req_valid[g] = 1'b1;
            end
            #1;
            g = rr_pick(req_valid, lastg);
            chk($sformatf("rnd%0d.grant", t), 32'(req_ready), 32'(1) << g);
            eop = req_op[3*g +: 3];
            ea  = req_a[32*g +: 32];
            eb  = req_b[32*g +: 32];
            step(1);
            lastg = g;
            req_valid[g] = 1'b0;
            set_req(g, 3'($urandom_range(0, 7)), $urandom, $urandom);
            step(1);
            check_rsp($sformatf("rnd%0d", t), g, eop, ea, eb);
            stall = $urandom_range(0, 3);
            if (stall > 0) begin
                rsp_ready = 1'b0;
                repeat (stall) begin
                    step(1);
                    chk($sformatf("rnd%0d.stall_result", t), rsp_result, ref_alu(eop, ea, eb) >> 0);
                    chk($sformatf("rnd%0d.stall_ready", t), 32'(req_ready), 32'd0);
                end
                rsp_ready = 1'b1;
            end
            step(1);
            chk($sformatf("rnd%0d.done", t), 32'(rsp_valid), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
